// File: rtl/event_capture_bank.sv
// Multi-channel sticky event capture: per-channel flags, saturating counters, first-event record, masked irq.
// Flags/counts update one cycle after a hit, irq one cycle later; no backpressure. `EVCAP_TIMESTAMP_EN adds ts_out.
module event_capture_bank #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 8,
   parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
`ifdef EVCAP_TIMESTAMP_EN
   ,
   parameter int TS_W   = 32
`endif
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [NUM_CH-1:0]       ev_in,
   input  logic [NUM_CH-1:0]       edge_mode,
   input  logic                    enable,
   input  logic [NUM_CH-1:0]       irq_mask,
   input  logic [NUM_CH-1:0]       clr,
   input  logic                    clr_all,
   output logic [NUM_CH-1:0]       flag,
   output logic [NUM_CH*CNT_W-1:0] count,
   output logic                    first_valid,
   output logic [IDX_W-1:0]        first_ch,
   output logic                    irq
`ifdef EVCAP_TIMESTAMP_EN
   ,
   output logic [NUM_CH*TS_W-1:0]  ts_out
`endif
);

   typedef enum logic {IDLE = 1'b0, CAPTURED = 1'b1} state_t;

   state_t            ch_state [NUM_CH];
   logic [CNT_W-1:0]  cnt_q    [NUM_CH];
   logic [NUM_CH-1:0] prev;
   logic [NUM_CH-1:0] hit;
   logic [NUM_CH-1:0] clr_any;
   logic [IDX_W-1:0]  low_idx;

   // prev tracks ev_in unconditionally so a mode switch never sees stale history
   assign hit     = {NUM_CH{enable}} & ((edge_mode & ev_in & ~prev) | (~edge_mode & ev_in));
   assign clr_any = clr | {NUM_CH{clr_all}};

   always_comb begin
      low_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (hit[i]) low_idx = IDX_W'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         prev        <= '0;
         first_valid <= 1'b0;
         first_ch    <= '0;
         irq         <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            ch_state[i] <= IDLE;
            cnt_q[i]    <= '0;
         end
      end else begin
         prev <= ev_in;
         irq  <= |(flag & irq_mask);
         for (int i = 0; i < NUM_CH; i++) begin
            if (hit[i]) begin
               // a hit colliding with a clear opens the new epoch at count 1
               ch_state[i] <= CAPTURED;
               if (clr_any[i])
                  cnt_q[i] <= CNT_W'(1);
               else if (cnt_q[i] != {CNT_W{1'b1}})
                  cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end else if (clr_any[i]) begin
               ch_state[i] <= IDLE;
               cnt_q[i]    <= '0;
            end
         end
         if (!first_valid || clr_all) begin
            if (|hit) begin
               first_valid <= 1'b1;
               first_ch    <= low_idx;
            end else if (clr_all) begin
               first_valid <= 1'b0;
               first_ch    <= '0;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_out
      assign flag[g]                 = (ch_state[g] == CAPTURED);
      assign count[g*CNT_W +: CNT_W] = cnt_q[g];
   end

`ifdef EVCAP_TIMESTAMP_EN
   logic [TS_W-1:0] ts_timer;
   logic [TS_W-1:0] ts_q [NUM_CH];

   // capture on IDLE->CAPTURED, which includes a hit that coincides with a clear
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ts_timer <= '0;
         for (int i = 0; i < NUM_CH; i++) ts_q[i] <= '0;
      end else begin
         ts_timer <= ts_timer + TS_W'(1);
         for (int i = 0; i < NUM_CH; i++) begin
            if (hit[i] && (!flag[i] || clr_any[i])) ts_q[i] <= ts_timer;
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ts
      assign ts_out[g*TS_W +: TS_W] = ts_q[g];
   end
`endif

endmodule

// File: tb/tb_event_capture_bank.sv
// Directed table-driven bench for event_capture_bank (NUM_CH=4, CNT_W=8).
module tb_event_capture_bank;

   logic        clk;
   logic        resetn;
   logic [3:0]  ev_in, edge_mode, irq_mask, clr;
   logic        enable, clr_all;
   logic [3:0]  flag;
   logic [31:0] count;
   logic        first_valid;
   logic [1:0]  first_ch;
   logic        irq;
`ifdef EVCAP_TIMESTAMP_EN
   logic [127:0] ts_out;
`endif

   int errors = 0;
   int checks = 0;

   event_capture_bank dut (
      .clk         (clk),
      .resetn      (resetn),
      .ev_in       (ev_in),
      .edge_mode   (edge_mode),
      .enable      (enable),
      .irq_mask    (irq_mask),
      .clr         (clr),
      .clr_all     (clr_all),
      .flag        (flag),
      .count       (count),
      .first_valid (first_valid),
      .first_ch    (first_ch),
      .irq         (irq)
`ifdef EVCAP_TIMESTAMP_EN
      ,
      .ts_out      (ts_out)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  ev;
      logic [3:0]  em;
      logic        en;
      logic [3:0]  mask;
      logic [3:0]  clr;
      logic        clr_all;
      logic [3:0]  flag;
      logic [31:0] cnt;
      logic        fv;
      logic [1:0]  fc;
      logic        irq;
   } vec_t;

   vec_t vecs [14];

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      //          ev    em     en    mask   clr    ca    flag   count         fv    fc     irq
      vecs[0]  = '{4'h0, 4'hF, 1'b1, 4'h0, 4'h0, 1'b1, 4'h0, 32'h00000000, 1'b0, 2'd0, 1'b0};
      vecs[1]  = '{4'h6, 4'h4, 1'b1, 4'h4, 4'h0, 1'b0, 4'h6, 32'h00010100, 1'b1, 2'd1, 1'b0};
      vecs[2]  = '{4'h6, 4'h4, 1'b1, 4'h4, 4'h0, 1'b0, 4'h6, 32'h00010200, 1'b1, 2'd1, 1'b1};
      vecs[3]  = '{4'h6, 4'h4, 1'b1, 4'h4, 4'h0, 1'b0, 4'h6, 32'h00010300, 1'b1, 2'd1, 1'b1};
      vecs[4]  = '{4'h6, 4'h4, 1'b1, 4'h4, 4'h0, 1'b0, 4'h6, 32'h00010400, 1'b1, 2'd1, 1'b1};
      vecs[5]  = '{4'h6, 4'h4, 1'b1, 4'h4, 4'h0, 1'b0, 4'h6, 32'h00010500, 1'b1, 2'd1, 1'b1};
      vecs[6]  = '{4'h0, 4'h4, 1'b1, 4'h0, 4'h0, 1'b0, 4'h6, 32'h00010500, 1'b1, 2'd1, 1'b0};
      vecs[7]  = '{4'h1, 4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 4'h7, 32'h00010501, 1'b1, 2'd1, 1'b0};
      vecs[8]  = '{4'h0, 4'hF, 1'b1, 4'h0, 4'h2, 1'b0, 4'h5, 32'h00010001, 1'b1, 2'd1, 1'b0};
      vecs[9]  = '{4'hF, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0, 4'h5, 32'h00010001, 1'b1, 2'd1, 1'b0};
      vecs[10] = '{4'h0, 4'hF, 1'b0, 4'hF, 4'h0, 1'b0, 4'h5, 32'h00010001, 1'b1, 2'd1, 1'b1};
      vecs[11] = '{4'h0, 4'hF, 1'b1, 4'hF, 4'h0, 1'b1, 4'h0, 32'h00000000, 1'b0, 2'd0, 1'b1};
      vecs[12] = '{4'h8, 4'hF, 1'b1, 4'hF, 4'h0, 1'b1, 4'h8, 32'h01000000, 1'b1, 2'd3, 1'b0};
      vecs[13] = '{4'h0, 4'hF, 1'b1, 4'hF, 4'h0, 1'b0, 4'h8, 32'h01000000, 1'b1, 2'd3, 1'b1};

      // reset with inputs active
      resetn = 1'b0; ev_in = 4'hF; edge_mode = 4'hF; enable = 1'b1;
      irq_mask = 4'h0; clr = 4'h0; clr_all = 1'b0;
      step(3);
      chk("rst_flag", 32'(flag), 32'h0);
      chk("rst_count", count, 32'h0);
      chk("rst_first_valid", 32'(first_valid), 32'h0);
      chk("rst_first_ch", 32'(first_ch), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);

      // input already high at release counts as one edge
      resetn = 1'b1;
      step(1);
      chk("rel_flag", 32'(flag), 32'hF);
      chk("rel_count", count, 32'h01010101);
      chk("rel_first_valid", 32'(first_valid), 32'h1);
      chk("rel_first_ch", 32'(first_ch), 32'h0);
      step(1);
      chk("held_count", count, 32'h01010101);

      for (int v = 0; v < 14; v++) begin
         ev_in = vecs[v].ev; edge_mode = vecs[v].em; enable = vecs[v].en;
         irq_mask = vecs[v].mask; clr = vecs[v].clr; clr_all = vecs[v].clr_all;
         step(1);
         chk($sformatf("v%0d_flag", v), 32'(flag), 32'(vecs[v].flag));
         chk($sformatf("v%0d_count", v), count, vecs[v].cnt);
         chk($sformatf("v%0d_first_valid", v), 32'(first_valid), 32'(vecs[v].fv));
         chk($sformatf("v%0d_first_ch", v), 32'(first_ch), 32'(vecs[v].fc));
         chk($sformatf("v%0d_irq", v), 32'(irq), 32'(vecs[v].irq));
      end
      clr_all = 1'b0;

      // build ch3 count up to 7 with edge pulses, then collide a clear with a pulse
      edge_mode = 4'hF;
      for (int p = 0; p < 6; p++) begin
         ev_in = 4'h8; step(1);
         ev_in = 4'h0; step(1);
      end
      chk("coll_pre_count", count, 32'h07000000);
      ev_in = 4'h8; clr = 4'h8; step(1);
      chk("coll_count", count, 32'h01000000);
      chk("coll_flag", 32'(flag), 32'h8);
      ev_in = 4'h0; clr = 4'h8; step(1);
      chk("lone_clr_count", count, 32'h0);
      chk("lone_clr_flag", 32'(flag), 32'h0);
      clr = 4'h0;

      // ch0 level mode saturation
      edge_mode = 4'hE; ev_in = 4'h1;
      step(300);
      chk("sat_count", count, 32'h000000FF);
      chk("sat_flag", 32'(flag), 32'h1);
      step(5);
      chk("sat_hold", count, 32'h000000FF);

      // reset mid-operation overrides simultaneous hits
      ev_in = 4'hF; edge_mode = 4'h0; resetn = 1'b0;
      step(1);
      chk("midrst_flag", 32'(flag), 32'h0);
      chk("midrst_count", count, 32'h0);
      chk("midrst_first_valid", 32'(first_valid), 32'h0);
      chk("midrst_irq", 32'(irq), 32'h0);

`ifdef EVCAP_TIMESTAMP_EN
      ev_in = 4'h0; edge_mode = 4'hF; irq_mask = 4'h0;
      step(1);
      resetn = 1'b1;
      step(100);
      ev_in = 4'h1; step(1);
      chk("ts_capture", ts_out[31:0], 32'd100);
      ev_in = 4'h0; step(1);
      step(48);
      ev_in = 4'h1; step(1);
      chk("ts_hold", ts_out[31:0], 32'd100);
      chk("ts_hold_count", count, 32'h00000002);
      ev_in = 4'h0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
